// File: rtl/exec_alu_if.sv
// Operand/opcode and result/branch bundle between the Execute stage and the ALU.
// master = the side that supplies operands, slave = the ALU itself.
interface exec_alu_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] result;
  logic             branch;

  modport master (output a, b, alu_op, input result, branch);
  modport slave  (input a, b, alu_op, output result, branch);
endinterface

// File: rtl/exec_alu.sv
// Execute-stage integer ALU.
// A single combinational datapath selects one of the arithmetic, logic, shift,
// compare, multiply or LUI results, or evaluates a branch condition. The outcome
// is captured on the next rising clk, so result/branch lag their inputs by one cycle.
// Branch opcodes leave result at zero and non-branch opcodes leave branch low,
// so consumers never see a stale value on the field they ignore.
module exec_alu #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  exec_alu_if.slave  bus
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam logic [3:0] OP_LUI = 4'b1010;
  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_BNE = 4'b1101;
  localparam logic [3:0] OP_BGT = 4'b1110;
  localparam logic [3:0] OP_BLT = 4'b1111;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic [4:0]              shamt_s;
  logic signed [WIDTH-1:0] a_sgn_s;
  logic signed [WIDTH-1:0] b_sgn_s;
  logic [WIDTH-1:0]        result_s;
  logic                    branch_s;
  logic [WIDTH-1:0]        result_r;
  logic                    branch_r;

  // Only the low five bits of b form a shift amount; upper bits are ignored.
  assign shamt_s = bus.b[4:0];
  assign a_sgn_s = $signed(bus.a);
  assign b_sgn_s = $signed(bus.b);

  // Select the operation result or branch condition for the current opcode.
  always_comb begin
    result_s = ZERO;
    branch_s = 1'b0;
    case (bus.alu_op)
      OP_ADD: result_s = bus.a + bus.b;
      OP_SUB: result_s = bus.a - bus.b;
      OP_XOR: result_s = bus.a ^ bus.b;
      OP_OR:  result_s = bus.a | bus.b;
      OP_AND: result_s = bus.a & bus.b;
      OP_SLL: result_s = bus.a << shamt_s;
      OP_SRL: result_s = bus.a >> shamt_s;
      OP_SRA: result_s = $unsigned(a_sgn_s >>> shamt_s);
      OP_SLT: result_s = {{(WIDTH-1){1'b0}}, (a_sgn_s < b_sgn_s)};
      // Low half of a product is identical for signed and unsigned operands.
      OP_MUL: result_s = bus.a * bus.b;
      OP_LUI: result_s = {bus.b[WIDTH-13:0], 12'h000};
      OP_BEQ: branch_s = (bus.a == bus.b);
      OP_BNE: branch_s = (bus.a != bus.b);
      OP_BGT: branch_s = (a_sgn_s > b_sgn_s);
      OP_BLT: branch_s = (a_sgn_s < b_sgn_s);
      // Reserved opcode 1011: both outputs stay at zero.
      default: begin
        result_s = ZERO;
        branch_s = 1'b0;
      end
    endcase
  end

  // Capture the selected value every cycle; reset clears both outputs at once
  // and drops whatever operation was in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= ZERO;
      branch_r <= 1'b0;
    end else begin
      result_r <= result_s;
      branch_r <= branch_s;
    end
  end

  assign bus.result = result_r;
  assign bus.branch = branch_r;

endmodule

// File: tb/tb_exec_alu.sv
// Directed and randomised checks for exec_alu with one cycle of output latency.
module tb_exec_alu;

  localparam int W = 32;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_SLL = 4'h5;
  localparam logic [3:0] OP_SRL = 4'h6;
  localparam logic [3:0] OP_SRA = 4'h7;
  localparam logic [3:0] OP_SLT = 4'h8;
  localparam logic [3:0] OP_MUL = 4'h9;
  localparam logic [3:0] OP_LUI = 4'hA;
  localparam logic [3:0] OP_RSV = 4'hB;
  localparam logic [3:0] OP_BEQ = 4'hC;
  localparam logic [3:0] OP_BNE = 4'hD;
  localparam logic [3:0] OP_BGT = 4'hE;
  localparam logic [3:0] OP_BLT = 4'hF;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  exec_alu_if #(.WIDTH(W)) bus ();

  exec_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model built on 64-bit signed arithmetic; returns {branch, result}.
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    longint      sx;
    longint      sy;
    logic [63:0] p;
    logic [31:0] r;
    logic        br;
    int          sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y[4:0]);
    r  = 32'h0;
    br = 1'b0;
    p  = 64'h0;
    case (op)
      OP_ADD: r = 32'(sx + sy);
      OP_SUB: r = 32'(sx - sy);
      OP_XOR: r = x ^ y;
      OP_OR:  r = x | y;
      OP_AND: r = x & y;
      OP_SLL: begin p = {32'h0, x} << sh; r = p[31:0]; end
      OP_SRL: begin p = {32'h0, x} >> sh; r = p[31:0]; end
      OP_SRA: begin p = 64'(sx) >> sh;     r = p[31:0]; end
      OP_SLT: r = (sx < sy) ? 32'h1 : 32'h0;
      OP_MUL: begin p = 64'(sx * sy); r = p[31:0]; end
      OP_LUI: begin p = {32'h0, y} * 64'd4096; r = p[31:0]; end
      OP_BEQ: br = (sx == sy);
      OP_BNE: br = (sx != sy);
      OP_BGT: br = (sx > sy);
      OP_BLT: br = (sx < sy);
      default: begin r = 32'h0; br = 1'b0; end
    endcase
    return {br, r};
  endfunction

  // Apply one operation and return #1 after the capturing edge.
  task automatic drive(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    bus.alu_op = op;
    bus.a      = x;
    bus.b      = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.alu_op = OP_ADD;
    bus.a      = 32'd5;
    bus.b      = 32'd7;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_async result=%h expected=%h", bus.result, 32'h0); end
    n_cmp++; if (bus.branch !== 1'b0) begin n_fail++; $display("FAIL reset_async branch=%b expected=0", bus.branch); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_held result=%h expected=%h", bus.result, 32'h0); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (bus.result !== 32'd12) begin n_fail++; $display("FAIL reset_release result=%h expected=%h", bus.result, 32'd12); end
    n_cmp++; if (bus.branch !== 1'b0) begin n_fail++; $display("FAIL reset_release branch=%b expected=0", bus.branch); end
  endtask

  task automatic test_arith_logic();
    logic [3:0]  t_op [6];
    logic [31:0] t_a [6];
    logic [31:0] t_b [6];
    logic [31:0] t_r [6];
    t_op = '{OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_RSV};
    t_a  = '{32'h7FFF_FFFF, 32'h0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hFFFF_FFFF};
    t_b  = '{32'h1, 32'h1, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'hFFFF_FFFF};
    t_r  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFF00_FF00, 32'hFFF0_FFF0, 32'h00F0_00F0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      drive(t_op[i], t_a[i], t_b[i]);
      n_cmp++; if (bus.result !== t_r[i]) begin n_fail++; $display("FAIL arith[%0d] op=%h result=%h expected=%h", i, t_op[i], bus.result, t_r[i]); end
      n_cmp++; if (bus.branch !== 1'b0) begin n_fail++; $display("FAIL arith_branch[%0d] branch=%b expected=0", i, bus.branch); end
    end
  endtask

  task automatic test_shifts();
    logic [3:0]  t_op [9];
    logic [31:0] t_b [9];
    logic [31:0] t_r [9];
    t_op = '{OP_SLL, OP_SRL, OP_SRA, OP_SLL, OP_SRL, OP_SRA, OP_SLL, OP_SRL, OP_SRA};
    t_b  = '{32'hFFFF_FFE4, 32'hFFFF_FFE4, 32'hFFFF_FFE4,
             32'hFFFF_FFE0, 32'hFFFF_FFE0, 32'hFFFF_FFE0,
             32'h0000_001F, 32'h0000_001F, 32'h0000_001F};
    t_r  = '{32'h0000_0010, 32'h0800_0000, 32'hF800_0000,
             32'h8000_0001, 32'h8000_0001, 32'h8000_0001,
             32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    for (int i = 0; i < 9; i++) begin
      drive(t_op[i], 32'h8000_0001, t_b[i]);
      n_cmp++; if (bus.result !== t_r[i]) begin n_fail++; $display("FAIL shift[%0d] op=%h result=%h expected=%h", i, t_op[i], bus.result, t_r[i]); end
      n_cmp++; if (bus.branch !== 1'b0) begin n_fail++; $display("FAIL shift_branch[%0d] branch=%b expected=0", i, bus.branch); end
    end
  endtask

  task automatic test_cmp_mul_lui();
    logic [3:0]  t_op [8];
    logic [31:0] t_a [8];
    logic [31:0] t_b [8];
    logic [31:0] t_r [8];
    t_op = '{OP_SLT, OP_SLT, OP_SLT, OP_SLT, OP_MUL, OP_MUL, OP_LUI, OP_LUI};
    t_a  = '{32'hFFFF_FFFF, 32'h1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_1234};
    t_b  = '{32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7, 32'h0001_0000, 32'h0000_ABCD, 32'hFFFF_FFFF};
    t_r  = '{32'h1, 32'h0, 32'h1, 32'h0, 32'hFFFF_FFEB, 32'h0, 32'h0ABC_D000, 32'hFFFF_F000};
    for (int i = 0; i < 8; i++) begin
      drive(t_op[i], t_a[i], t_b[i]);
      n_cmp++; if (bus.result !== t_r[i]) begin n_fail++; $display("FAIL cmp_mul_lui[%0d] op=%h result=%h expected=%h", i, t_op[i], bus.result, t_r[i]); end
      n_cmp++; if (bus.branch !== 1'b0) begin n_fail++; $display("FAIL cmp_mul_lui_branch[%0d] branch=%b expected=0", i, bus.branch); end
    end
  endtask

  task automatic test_branches();
    logic [3:0]  t_op [10];
    logic [31:0] t_a [10];
    logic [31:0] t_b [10];
    logic        t_br [10];
    t_op = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE, OP_BGT, OP_BGT, OP_BLT, OP_BLT, OP_BGT, OP_BLT};
    t_a  = '{32'd42, 32'd42, 32'd42, 32'd42, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    t_b  = '{32'd42, 32'd43, 32'd42, 32'd43, 32'hFFFF_FFFE, 32'd5, 32'h0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    t_br = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(t_op[i], t_a[i], t_b[i]);
      n_cmp++; if (bus.branch !== t_br[i]) begin n_fail++; $display("FAIL branch[%0d] op=%h branch=%b expected=%b", i, t_op[i], bus.branch, t_br[i]); end
      n_cmp++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL branch_result[%0d] result=%h expected=%h", i, bus.result, 32'h0); end
    end
  endtask

  task automatic test_random();
    logic [31:0] ra;
    logic [31:0] rb;
    logic [32:0] exp;
    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < 1000; k++) begin
        ra = $urandom;
        rb = $urandom;
        if ($urandom_range(0, 9) == 0) rb = ra;
        exp = model(4'(op), ra, rb);
        drive(4'(op), ra, rb);
        n_cmp++; if (bus.result !== exp[31:0]) begin n_fail++; $display("FAIL random op=%h a=%h b=%h result=%h expected=%h", op, ra, rb, bus.result, exp[31:0]); end
        n_cmp++; if (bus.branch !== exp[32]) begin n_fail++; $display("FAIL random_branch op=%h a=%h b=%h branch=%b expected=%b", op, ra, rb, bus.branch, exp[32]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xa;
    logic [31:0] xb;
    logic [32:0] prev;
    logic [32:0] exp;
    xa = 32'h1234_5678;
    xb = 32'hFFFF_FF83;
    prev = model(4'h0, xa, xb);
    drive(4'h0, xa, xb);
    for (int op = 1; op < 16; op++) begin
      xa = xa + 32'h0101_0101;
      xb = xb ^ 32'h8000_0011;
      exp = model(4'(op), xa, xb);
      bus.alu_op = 4'(op);
      bus.a      = xa;
      bus.b      = xb;
      #4;
      n_cmp++; if ({bus.branch, bus.result} !== prev) begin n_fail++; $display("FAIL b2b_hold op=%h got=%h expected=%h", op, {bus.branch, bus.result}, prev); end
      @(posedge clk);
      #1;
      n_cmp++; if ({bus.branch, bus.result} !== exp) begin n_fail++; $display("FAIL b2b op=%h got=%h expected=%h", op, {bus.branch, bus.result}, exp); end
      prev = exp;
    end
  endtask

  task automatic test_reset_mid();
    drive(OP_BEQ, 32'd9, 32'd9);
    n_cmp++; if (bus.branch !== 1'b1) begin n_fail++; $display("FAIL mid_pre branch=%b expected=1", bus.branch); end
    drive(OP_ADD, 32'd100, 32'd23);
    n_cmp++; if (bus.result !== 32'd123) begin n_fail++; $display("FAIL mid_pre result=%h expected=%h", bus.result, 32'd123); end
    bus.alu_op = OP_BEQ;
    bus.a      = 32'd1;
    bus.b      = 32'd1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL mid_reset result=%h expected=%h", bus.result, 32'h0); end
    n_cmp++; if (bus.branch !== 1'b0) begin n_fail++; $display("FAIL mid_reset branch=%b expected=0", bus.branch); end
    #1;
    bus.alu_op = OP_SUB;
    bus.a      = 32'd10;
    bus.b      = 32'd3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (bus.result !== 32'd7) begin n_fail++; $display("FAIL mid_release result=%h expected=%h", bus.result, 32'd7); end
    n_cmp++; if (bus.branch !== 1'b0) begin n_fail++; $display("FAIL mid_release branch=%b expected=0", bus.branch); end
  endtask

  // Abort a run that stops making progress.
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog timeout");
  end

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_arith_logic();
    test_shifts();
    test_cmp_mul_lui();
    test_branches();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
